calculator: RTL and testbench
=============================

// Module: calculator
// PURPOSE
//  - 4-bit unsigned ALU/calculator with a registered 8-bit result.
//  - Supports add, subtract, multiply, divide, modulo, AND, OR and XOR.
//  - Single-cycle ops return their result one cycle after acceptance.
//  - Divide and modulo use a multi-cycle restoring divider.
//  - Small datapath leaf; the host drives operands and an opcode and reads out/out_valid.
// PARAMETERS
//  - none; widths are fixed: operands 4 b, opcode 3 b, result 8 b.
// PORTS
//  clk        in   1  rising-edge clock; the only clock
//  rst_n      in   1  asynchronous, active-low reset
//  in_valid   in   1  request strobe; a/b/oper are sampled when in_valid && !busy
//  a          in   4  operand A, unsigned
//  b          in   4  operand B, unsigned
//  oper       in   3  opcode (see BEHAVIOUR)
//  out        out  8  result register; holds the last result until the next one completes
//  out_valid  out  1  one-cycle pulse when out is updated
//  busy       out  1  high while a divide/modulo is in progress; requests are ignored
// BEHAVIOUR
//  - Reset (async assert, sync release): out=8'h00, out_valid=0, busy=0, divider idle.
//  - Opcodes; operands are zero-extended to 8 b:
//      000 ADD : out = a + b                (max 30, never overflows)
//      001 SUB : out = (a - b) mod 256      (two's complement; 3-9 = 8'hFA)
//      010 MUL : out = a * b                (max 225)
//      011 DIV : out = a / b                (quotient)
//      100 MOD : out = a % b                (remainder)
//      101 AND : out = {4'h0, a & b}
//      110 OR  : out = {4'h0, a | b}
//      111 XOR : out = {4'h0, a ^ b}
//  - Single-cycle ops (000,001,010,101,110,111):
//      - Accepted at edge N.
//      - out and out_valid=1 at edge N+1; busy stays 0.
//      - Back-to-back requests are accepted every cycle.
//  - DIV/MOD:
//      - Accepted at edge N: busy=1 from edge N.
//      - Four restoring iterations, one bit per cycle, MSB first.
//      - At edge N+4: out written, out_valid=1, busy=0.
//      - A new request is accepted in the cycle where busy is low again.
//  - Divide by zero (b==0), no iterations:
//      - DIV: out = 8'hFF. MOD: out = {4'h0, a}.
//      - Same timing as a single-cycle op; busy is never raised.
//  - in_valid while busy: ignored, and the in-flight op is not disturbed.
//  - in_valid low: out holds its value and out_valid=0.
//  - Reset asserted mid-division: the op is aborted, all outputs return to their reset values, and no out_valid pulse is produced.
//  - Illegal opcodes: none; all 8 codes are defined.
// STRUCTURE
//  - Shared package calc_pkg:
//      - typedef enum logic [2:0] opcode_t: OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_XOR, encoded 000..111.
//      - Localparams OPW=4 and RESW=8.
//  - Sub-module calc_div:
//      - 4-bit sequential restoring divider.
//      - Ports: clk, rst_n, start, dividend, divisor, done, quotient, remainder.
//  - Top level: accept logic, combinational single-cycle ALU, result/valid registers, and a busy flag driven from calc_div.
// TESTING (for all vectors below, a=4'b1001, b=4'b0011; single-cycle ops are checked 1 cycle after acceptance)
//  1. Single-cycle ops with out_valid=1, busy=0:
//       oper=000 -> out=00001100 (12); oper=001 -> 00000110 (6); oper=010 -> 00011011 (27).
//  2. Divider ops: oper=011 -> busy high for 4 cycles, then out=00000011 (3) with a 1-cycle out_valid.
//       oper=100 -> out=00000000 after the same latency.
//  3. Logic ops: oper=101 -> 00000001; oper=110 -> 00001011; oper=111 -> 00001010.
//  4. Edge cases:
//       a=3,b=9,SUB -> 8'hFA; a=15,b=15,MUL -> 8'hE1.
//       a=7,b=0,DIV -> 8'hFF and a=7,b=0,MOD -> 8'h07, both after 1 cycle with no busy.
//  5. Issue a DIV, then hold in_valid with ADD while busy:
//       the ADD is ignored and DIV completes correctly.
//       The ADD is accepted once busy falls; out=12 on the next edge.
//  6. Reset cases:
//       Assert rst_n=0 two cycles into a DIV -> out=0, out_valid=0, busy=0 immediately; no later out_valid.
//       Release, then ADD 9+3 -> 12.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and widths for the 4-bit calculator and its divider.
package calc_pkg;

  localparam int OPW  = 4;
  localparam int RESW = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_MOD = 3'b100,
    OP_AND = 3'b101,
    OP_OR  = 3'b110,
    OP_XOR = 3'b111
  } opcode_t;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_RUN  = 1'b1
  } div_state_t;

  // True for the opcodes that go through the multi-cycle divider.
  function automatic logic is_div_op(input opcode_t op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/calculator_if.sv
// Host-side request/result bundle for the calculator.
// Handshake: a request is taken on a rising edge where in_valid=1 and
// busy=0 (busy is the inverse of ready); a/b/oper only matter on that edge.
// out_valid is a one-cycle pulse marking the edge at which out was updated.
interface calculator_if
  import calc_pkg::*;
();
  logic            in_valid;
  logic [OPW-1:0]  a;
  logic [OPW-1:0]  b;
  opcode_t         oper;
  logic [RESW-1:0] out;
  logic            out_valid;
  logic            busy;

  modport master (output in_valid, a, b, oper, input out, out_valid, busy);
  modport slave  (input in_valid, a, b, oper, output out, out_valid, busy);
endinterface

// File: rtl/calc_div.sv
// 4-bit sequential restoring divider, one quotient bit per cycle, MSB first.
// The load happens on the start edge; the fourth iteration's result is
// presented combinationally with done so the caller can register it on
// the same edge the divider returns to idle.
module calc_div
  import calc_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [OPW-1:0] dividend,
  input  logic [OPW-1:0] divisor,
  output logic           done,
  output logic [OPW-1:0] quotient,
  output logic [OPW-1:0] remainder,
  output div_state_t     state
);

  div_state_t     next_state;
  logic [OPW-1:0] q_r;
  logic [OPW-1:0] rem_r;
  logic [OPW-1:0] dvs_r;
  logic [1:0]     cnt_r;
  logic [OPW:0]   rem_sh;
  logic [OPW-1:0] rem_nx;
  logic [OPW-1:0] q_nx;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh = {rem_r, q_r[OPW-1]};
    rem_nx = rem_sh[OPW-1:0];
    q_nx   = {q_r[OPW-2:0], 1'b0};
    if (rem_sh >= {1'b0, dvs_r}) begin
      rem_nx = 4'(rem_sh - {1'b0, dvs_r});
      q_nx   = {q_r[OPW-2:0], 1'b1};
    end
  end

  assign quotient  = q_nx;
  assign remainder = rem_nx;

  // Next-state and done: finish after the fourth iteration.
  always_comb begin
    next_state = state;
    done       = 1'b0;
    case (state)
      DIV_IDLE: if (start) next_state = DIV_RUN;
      DIV_RUN: begin
        if (cnt_r == 2'd3) begin
          done       = 1'b1;
          next_state = DIV_IDLE;
        end
      end
      default: next_state = DIV_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DIV_IDLE;
    else        state <= next_state;
  end

  // Datapath: load operands on start, iterate while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r   <= '0;
      rem_r <= '0;
      dvs_r <= '0;
      cnt_r <= '0;
    end else if (state == DIV_IDLE && start) begin
      q_r   <= dividend;
      rem_r <= '0;
      dvs_r <= divisor;
      cnt_r <= '0;
    end else if (state == DIV_RUN) begin
      q_r   <= q_nx;
      rem_r <= rem_nx;
      cnt_r <= cnt_r + 2'd1;
    end
  end

endmodule

// File: rtl/calculator.sv
// 4-bit calculator: single-cycle ALU ops plus DIV/MOD through calc_div.
// Divide by zero never reaches the divider; it is resolved in the ALU.
module calculator
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  calculator_if.slave bus,
  output div_state_t div_state
);

  logic            busy;
  logic            accept;
  logic            start;
  logic            div_done;
  logic [OPW-1:0]  quo;
  logic [OPW-1:0]  rem;
  logic            is_mod_r;
  logic [RESW-1:0] a8;
  logic [RESW-1:0] b8;
  logic [RESW-1:0] alu;

  assign busy     = (div_state == DIV_RUN);
  assign bus.busy = busy;
  assign accept   = bus.in_valid && !busy;
  assign start    = accept && is_div_op(bus.oper) && (bus.b != '0);
  assign a8       = {4'h0, bus.a};
  assign b8       = {4'h0, bus.b};

  calc_div u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (bus.a),
    .divisor   (bus.b),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem),
    .state     (div_state)
  );

  // Single-cycle ALU; DIV/MOD entries here only cover the b==0 case.
  always_comb begin
    alu = '0;
    case (bus.oper)
      OP_ADD:  alu = a8 + b8;
      OP_SUB:  alu = a8 - b8;
      OP_MUL:  alu = a8 * b8;
      OP_DIV:  alu = 8'hFF;
      OP_MOD:  alu = a8;
      OP_AND:  alu = a8 & b8;
      OP_OR:   alu = a8 | b8;
      OP_XOR:  alu = a8 ^ b8;
      default: alu = '0;
    endcase
  end

  // Remember which divider result (quotient or remainder) to publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     is_mod_r <= 1'b0;
    else if (start) is_mod_r <= (bus.oper == OP_MOD);
  end

  // Result register and one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (div_done) begin
        bus.out       <= is_mod_r ? {4'h0, rem} : {4'h0, quo};
        bus.out_valid <= 1'b1;
      end else if (accept && !start) begin
        bus.out       <= alu;
        bus.out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_calculator.sv
// Bench for calculator: directed spec vectors, random traffic against a
// transaction-level model, and reset-abort of an in-flight divide.
module tb_calculator;
  import calc_pkg::*;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  calculator_if bus ();
  div_state_t   div_state;

  calculator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .div_state (div_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard and model state.
  logic [7:0] exp_q[$];
  int         mdl_cnt = 0;
  logic [7:0] mdl_out = 8'h00;
  logic [7:0] mdl_pend = 8'h00;
  logic       exp_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Result straight from the opcode table, using integer arithmetic.
  function automatic logic [7:0] ref_result(input int ia, input int ib, input int op);
    int r;
    case (op)
      0: r = ia + ib;
      1: r = (ia - ib + 256) % 256;
      2: r = ia * ib;
      3: r = (ib == 0) ? 255 : ia / ib;
      4: r = (ib == 0) ? ia : ia % ib;
      5: r = ia & ib;
      6: r = ia | ib;
      default: r = ia ^ ib;
    endcase
    return 8'(r);
  endfunction

  // Drive one cycle of request, advance the model, compare after the edge.
  task automatic cycle(input logic v, input int a, input int b, input int op);
    logic accept;
    logic [7:0] r;
    @(negedge clk);
    bus.in_valid = v;
    bus.a        = 4'(a);
    bus.b        = 4'(b);
    bus.oper     = opcode_t'(3'(op));
    @(posedge clk);
    accept    = v && (mdl_cnt == 0);
    exp_valid = 1'b0;
    r         = ref_result(a, b, op);
    if (mdl_cnt > 0) begin
      mdl_cnt--;
      if (mdl_cnt == 0) begin
        mdl_out   = mdl_pend;
        exp_valid = 1'b1;
      end
    end else if (accept) begin
      exp_q.push_back(r);
      if ((op == 3 || op == 4) && b != 0) begin
        mdl_cnt  = 4;
        mdl_pend = r;
      end else begin
        mdl_out   = r;
        exp_valid = 1'b1;
      end
    end
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    check("busy", 32'(bus.busy), 32'(mdl_cnt > 0));
    check("out", 32'(bus.out), 32'(mdl_out));
    check("div_state_active", 32'(div_state != DIV_IDLE), 32'(mdl_cnt > 0));
    if (bus.out_valid) begin
      if (exp_q.size() == 0) check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
      else                   check("scoreboard", 32'(bus.out), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0);
  endtask

  task automatic model_reset();
    mdl_cnt = 0;
    mdl_out = 8'h00;
    exp_q.delete();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.oper     = OP_ADD;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", 32'(bus.out), 32'h00);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Spec vectors, a=9 b=3.
    cycle(1'b1, 9, 3, 0); check("add_9_3", 32'(bus.out), 32'd12);
    cycle(1'b1, 9, 3, 1); check("sub_9_3", 32'(bus.out), 32'd6);
    cycle(1'b1, 9, 3, 2); check("mul_9_3", 32'(bus.out), 32'd27);
    cycle(1'b1, 9, 3, 3); check("div_busy_start", 32'(bus.busy), 32'd1);
    idle(4);              check("div_9_3", 32'(bus.out), 32'd3);
    cycle(1'b1, 9, 3, 4);
    idle(4);              check("mod_9_3", 32'(bus.out), 32'd0);
    cycle(1'b1, 9, 3, 5); check("and_9_3", 32'(bus.out), 32'h01);
    cycle(1'b1, 9, 3, 6); check("or_9_3", 32'(bus.out), 32'h0B);
    cycle(1'b1, 9, 3, 7); check("xor_9_3", 32'(bus.out), 32'h0A);

    // Edge cases.
    cycle(1'b1, 3, 9, 1);   check("sub_3_9", 32'(bus.out), 32'hFA);
    cycle(1'b1, 15, 15, 2); check("mul_15_15", 32'(bus.out), 32'hE1);
    cycle(1'b1, 7, 0, 3);   check("div_by_zero", 32'(bus.out), 32'hFF);
    check("div0_no_busy", 32'(bus.busy), 32'd0);
    cycle(1'b1, 7, 0, 4);   check("mod_by_zero", 32'(bus.out), 32'h07);
    check("mod0_no_busy", 32'(bus.busy), 32'd0);

    // ADD held while DIV in flight: ignored until busy drops.
    cycle(1'b1, 15, 2, 3);
    for (int i = 0; i < 4; i++) cycle(1'b1, 9, 3, 0);
    check("div_15_2_under_add", 32'(bus.out), 32'd7);
    cycle(1'b1, 9, 3, 0);   check("add_after_busy", 32'(bus.out), 32'd12);
    idle(1);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
    idle(6);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Reset two cycles into a divide.
    cycle(1'b1, 13, 4, 3);
    idle(2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out", 32'(bus.out), 32'h00);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    cycle(1'b1, 9, 3, 0); check("add_after_reset", 32'(bus.out), 32'd12);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
